// File: rtl/sub_d_latch_arb.sv
// Round-robin arbiter that shares one transparent-latch slice between NREQ
// requesters, running a setup / enable-pulse / hold / ack write sequence per grant.
module sub_d_latch_arb #(
  parameter int NREQ      = 4,
  parameter int DW        = 1,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic                    testi1_clk,
  input  logic                    testi1_rst,
  input  logic [NREQ-1:0]         testi1_req,
  input  logic [NREQ*DW-1:0]      testi1_data,
  output logic [NREQ-1:0]         testo1_ack,
  output logic [DW-1:0]           testo1_sub_d,
  output logic                    testo1_sub_clk_d,
  output logic                    testo1_busy,
  output logic [$clog2(NREQ)-1:0] testo1_owner
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  generate
    if (SETUP_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cfg
      $error("sub_d_latch_arb: SETUP_CYC and HOLD_CYC must both be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_OPEN  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [DW-1:0]   sub_d_q, sub_d_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic            gnt_valid_s;
  logic [IW-1:0]   gnt_idx_s;
  logic [IW-1:0]   scan_idx_s;

  // Round-robin pick: scan from the highest slot offset down so the lowest offset from ptr wins.
  always_comb begin
    gnt_valid_s = |testi1_req;
    gnt_idx_s   = '0;
    scan_idx_s  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx_s = IW'((int'(ptr_q) + k) % NREQ);
      gnt_idx_s  = testi1_req[scan_idx_s] ? scan_idx_s : gnt_idx_s;
    end
  end

  // Sequencer next state; enable and ack are registered from the current state,
  // so the slice sees them one cycle after the FSM enters OPEN / ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sub_d_d = sub_d_q;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          owner_d = gnt_idx_s;
          sub_d_d = testi1_data[gnt_idx_s*DW +: DW];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_OPEN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_OPEN: begin
        state_d = ST_HOLD;
        cnt_d   = CW'(HOLD_CYC - 1);
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        ack_d[owner_q] = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    en_d   = (state_q == ST_OPEN);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops the enable immediately.
  always_ff @(posedge testi1_clk or posedge testi1_rst) begin
    if (testi1_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      sub_d_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      sub_d_q <= sub_d_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign testo1_ack       = ack_q;
  assign testo1_sub_d     = sub_d_q;
  assign testo1_sub_clk_d = en_q;
  assign testo1_busy      = busy_q;
  assign testo1_owner     = owner_q;

endmodule

// File: tb/tb_sub_d_latch_arb.sv
// Directed bench for sub_d_latch_arb: default instance plus a SETUP_CYC=3 /
// HOLD_CYC=2 instance, expected values hand-derived from the edge timeline.
module tb_sub_d_latch_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0, data = 4'd0;
  logic [3:0] req2 = 4'd0, data2 = 4'd0;
  logic [3:0] ack, ack2;
  logic       sub_d, sub_d2, en, en2, busy, busy2;
  logic [1:0] owner, owner2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sub_d_latch_arb dut (
    .testi1_clk(clk), .testi1_rst(rst), .testi1_req(req), .testi1_data(data),
    .testo1_ack(ack), .testo1_sub_d(sub_d), .testo1_sub_clk_d(en),
    .testo1_busy(busy), .testo1_owner(owner)
  );

  sub_d_latch_arb #(.NREQ(4), .DW(1), .SETUP_CYC(3), .HOLD_CYC(2)) dut2 (
    .testi1_clk(clk), .testi1_rst(rst), .testi1_req(req2), .testi1_data(data2),
    .testo1_ack(ack2), .testo1_sub_d(sub_d2), .testo1_sub_clk_d(en2),
    .testo1_busy(busy2), .testo1_owner(owner2)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_ack;
    int         exp_own;

    // 1: reset with random inputs, then idle
    req = 4'($urandom); data = 4'($urandom);
    req2 = 4'($urandom); data2 = 4'($urandom);
    repeat (3) step();
    chk_eq("rst_ack", ack, 32'd0);
    chk_eq("rst_en", en, 32'd0);
    chk_eq("rst_busy", busy, 32'd0);
    chk_eq("rst_owner", owner, 32'd0);
    chk_eq("rst_subd", sub_d, 32'd0);
    chk_eq("rst_busy2", busy2, 32'd0);
    rst = 1'b0; req = 4'd0; req2 = 4'd0;
    repeat (3) step();
    chk_eq("idle_busy", busy, 32'd0);
    chk_eq("idle_en", en, 32'd0);

    // 4: SETUP_CYC=3, HOLD_CYC=2 on slot 1
    req2 = 4'b0010; data2 = 4'b0010;
    step();
    chk_eq("t4_owner", owner2, 32'd1);
    chk_eq("t4_subd", sub_d2, 32'd1);
    chk_eq("t4_busy", busy2, 32'd1);
    for (int e = 1; e <= 8; e++) begin
      step();
      chk_eq($sformatf("t4_en_e%0d", e), en2, (e == 4) ? 32'd1 : 32'd0);
      chk_eq($sformatf("t4_ack_e%0d", e), ack2, (e == 7) ? 32'd2 : 32'd0);
      if (e == 7) req2 = 4'd0;
    end
    chk_eq("t4_busy_end", busy2, 32'd0);

    // 3: all four requesting, each drops after its ack and re-raises
    data = 4'b1010; req = 4'b1111;
    step();
    for (int t = 0; t < 5; t++) begin
      exp_own = t % 4;
      chk_eq($sformatf("t3_owner_%0d", t), owner, 32'(exp_own));
      chk_eq($sformatf("t3_subd_%0d", t), sub_d, 32'(data[exp_own]));
      chk_eq($sformatf("t3_busy_%0d", t), busy, 32'd1);
      step();
      chk_eq($sformatf("t3_en1_%0d", t), en, 32'd0);
      step();
      chk_eq($sformatf("t3_en2_%0d", t), en, 32'd1);
      step();
      chk_eq($sformatf("t3_ack3_%0d", t), ack, 32'd0);
      step();
      exp_ack = 4'd0;
      exp_ack[exp_own] = 1'b1;
      chk_eq($sformatf("t3_ack4_%0d", t), ack, 32'(exp_ack));
      if (t == 4) req = 4'd0;
      else req[exp_own] = 1'b0;
      step();
      if (t < 4) req[exp_own] = 1'b1;
    end
    chk_eq("t3_ack_end", ack, 32'd0);
    chk_eq("t3_busy_end", busy, 32'd0);

    // 2: single request on slot 2
    req = 4'b0100; data = 4'b0100;
    step();
    chk_eq("t2_owner", owner, 32'd2);
    chk_eq("t2_subd", sub_d, 32'd1);
    step();
    chk_eq("t2_en1", en, 32'd0);
    step();
    chk_eq("t2_en2", en, 32'd1);
    step();
    chk_eq("t2_en3", en, 32'd0);
    chk_eq("t2_ack3", ack, 32'd0);
    step();
    chk_eq("t2_ack4", ack, 32'h4);
    req = 4'd0;
    step();
    chk_eq("t2_ack5", ack, 32'd0);
    chk_eq("t2_busy5", busy, 32'd0);
    chk_eq("t2_subd_hold", sub_d, 32'd1);
    chk_eq("t2_owner_hold", owner, 32'd2);

    // 6: owner drops req in SETUP, data changes in HOLD
    req = 4'b0100; data = 4'b0000;
    step();
    chk_eq("t6_owner", owner, 32'd2);
    chk_eq("t6_subd0", sub_d, 32'd0);
    req = 4'd0;
    step();
    step();
    chk_eq("t6_en2", en, 32'd1);
    step();
    data = 4'b0100;
    chk_eq("t6_subd3", sub_d, 32'd0);
    step();
    chk_eq("t6_ack4", ack, 32'h4);
    chk_eq("t6_subd4", sub_d, 32'd0);
    step();
    chk_eq("t6_busy5", busy, 32'd0);

    // 5: reset while enable is high, then pointer restarts at 0
    req = 4'b0100; data = 4'b0000;
    step();
    chk_eq("t5_owner", owner, 32'd2);
    req = 4'd0;
    step();
    step();
    chk_eq("t5_en_open", en, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_eq("t5_en_async", en, 32'd0);
    chk_eq("t5_busy_rst", busy, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_eq($sformatf("t5_noack_%0d", c), ack, 32'd0);
    end
    rst = 1'b0; req = 4'b1010; data = 4'b0010;
    step();
    chk_eq("t5_owner_ptr0", owner, 32'd1);
    chk_eq("t5_subd", sub_d, 32'd1);
    step();
    step();
    step();
    step();
    chk_eq("t5_ack", ack, 32'h2);
    req = 4'd0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
